// File: rtl/ram_port_arbiter.sv
// Front end for a 1W/1R RAM: optional post-reset init sweep, round-robin write arbitration
// and a stall-capable read stream. Define RAM_ARB_INIT_SWEEP_EN to enable the INIT_VALUE sweep.
module ram_port_arbiter #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    NUM_REQ    = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            wr_valid,
    output logic [NUM_REQ-1:0]            wr_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]         rd_req_addr,
    output logic                          rd_rsp_valid,
    input  logic                          rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]         rd_rsp_data,
    output logic [ADDR_WIDTH-1:0]         ram_write_addr,
    output logic [DATA_WIDTH-1:0]         ram_write_data,
    output logic                          ram_write_enable,
    output logic [ADDR_WIDTH-1:0]         ram_read_addr,
    input  logic [DATA_WIDTH-1:0]         ram_read_data,
    output logic                          ram_read_ready,
    output logic                          init_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  w_run;
    logic                  w_sweep;
    logic [ADDR_WIDTH-1:0] w_sweepAddr;
    logic [PW-1:0]         r_rrPtr;
    logic [PW-1:0]         w_grantIdx;
    logic                  w_grantValid;
    logic                  w_wrAccept;
    logic                  r_wrEn;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic                  r_rspValid;
    logic                  w_rdReqReady;
    logic                  w_rdFire;

`ifdef RAM_ARB_INIT_SWEEP_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_initCount;

    // The counter wraps to zero on the last address, which is also when we leave INIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_initCount <= '0;
        end else if (r_state == ST_INIT) begin
            r_initCount <= r_initCount + 1'b1;
            if (r_initCount == {ADDR_WIDTH{1'b1}})
                r_state <= ST_RUN;
        end
    end

    assign w_run       = (r_state == ST_RUN);
    assign w_sweep     = (r_state == ST_INIT);
    assign w_sweepAddr = r_initCount;
`else
    logic r_initDone;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_initDone <= 1'b0;
        else
            r_initDone <= 1'b1;
    end

    assign w_run       = r_initDone;
    assign w_sweep     = 1'b0;
    assign w_sweepAddr = '0;
`endif

    assign init_done = w_run;

    // Search upward from the pointer, wrapping, for the first valid requester
    always_comb begin
        int idx;
        idx          = 0;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(r_rrPtr) + off;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!w_grantValid && wr_valid[idx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = PW'(idx);
            end
        end
    end

    assign w_wrAccept = w_run && w_grantValid;

    always_comb begin
        wr_ready = '0;
        if (w_wrAccept)
            wr_ready[w_grantIdx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_rrPtr  <= '0;
        end else if (w_sweep) begin
            r_wrEn   <= 1'b1;
            r_wrAddr <= w_sweepAddr;
            r_wrData <= INIT_VALUE;
        end else if (w_wrAccept) begin
            r_wrEn   <= 1'b1;
            r_wrAddr <= wr_addr[w_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
            r_wrData <= wr_data[w_grantIdx*DATA_WIDTH +: DATA_WIDTH];
            r_rrPtr  <= (w_grantIdx == PW'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
        end else begin
            r_wrEn   <= 1'b0;
        end
    end

    assign ram_write_enable = r_wrEn;
    assign ram_write_addr   = r_wrAddr;
    assign ram_write_data   = r_wrData;

    // The RAM output register is the response buffer; it only advances on an accepted request
    assign w_rdReqReady = w_run && (!r_rspValid || rd_rsp_ready);
    assign w_rdFire     = rd_req_valid && w_rdReqReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rspValid <= 1'b0;
        else if (w_rdReqReady)
            r_rspValid <= w_rdFire;
    end

    assign rd_req_ready   = w_rdReqReady;
    assign ram_read_addr  = rd_req_addr;
    assign ram_read_ready = w_rdFire;
    assign rd_rsp_valid   = r_rspValid;
    assign rd_rsp_data    = ram_read_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: behavioural RAM, transaction-level reference model,
// directed round-robin/read-stream cases followed by randomized traffic.
module tb_ram_port_arbiter;

    localparam int        DW    = 8;
    localparam int        AW    = 4;
    localparam int        NR    = 4;
    localparam int        DEPTH = 16;
    localparam logic [DW-1:0] INITV = 8'hA5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     wrValid = '0;
    logic [NR-1:0]     wrReady;
    logic [NR*AW-1:0]  wrAddr = '0;
    logic [NR*DW-1:0]  wrData = '0;
    logic              rdReqValid = 1'b0;
    logic              rdReqReady;
    logic [AW-1:0]     rdReqAddr = '0;
    logic              rdRspValid;
    logic              rdRspReady = 1'b0;
    logic [DW-1:0]     rdRspData;
    logic [AW-1:0]     ramWriteAddr;
    logic [DW-1:0]     ramWriteData;
    logic              ramWriteEnable;
    logic [AW-1:0]     ramReadAddr;
    logic [DW-1:0]     ramReadData = '0;
    logic              ramReadReady;
    logic              initDone;

    logic [DW-1:0]     mem [DEPTH];

    int vectors = 0;
    int errors  = 0;

    // Reference model state: next-cycle RAM write, shadow memory, pending response
    int              mdlPtr = 0;
    bit              pendWrValid = 1'b0;
    logic [AW-1:0]   pendWrAddr = '0;
    logic [DW-1:0]   pendWrData = '0;
    logic [DW-1:0]   expMem [DEPTH];
    bit              expKnown [DEPTH];
    bit              mdlRspValid = 1'b0;
    bit              mdlRspKnown = 1'b0;
    logic [DW-1:0]   mdlRspData = '0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .INIT_VALUE (INITV)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_valid         (wrValid),
        .wr_ready         (wrReady),
        .wr_addr          (wrAddr),
        .wr_data          (wrData),
        .rd_req_valid     (rdReqValid),
        .rd_req_ready     (rdReqReady),
        .rd_req_addr      (rdReqAddr),
        .rd_rsp_valid     (rdRspValid),
        .rd_rsp_ready     (rdRspReady),
        .rd_rsp_data      (rdRspData),
        .ram_write_addr   (ramWriteAddr),
        .ram_write_data   (ramWriteData),
        .ram_write_enable (ramWriteEnable),
        .ram_read_addr    (ramReadAddr),
        .ram_read_data    (ramReadData),
        .ram_read_ready   (ramReadReady),
        .init_done        (initDone)
    );

    // Single-clock RAM: registered read that holds while read_ready is low
    always @(posedge clk) begin
        if (ramWriteEnable)
            mem[ramWriteAddr] <= ramWriteData;
        if (ramReadReady)
            ramReadData <= mem[ramReadAddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One RUN-state cycle: drive inputs, compare against the model, then advance the model
    task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                                 input logic [NR*DW-1:0] d, input logic rv,
                                 input logic [AW-1:0] ra, input logic rr);
        logic [NR-1:0] expReady;
        int            g;
        int            c;
        bit            expReqReady;
        bit            fire;
        logic [DW-1:0] rdVal;
        bit            rdKnown;
        @(negedge clk);
        wrValid    = v;
        wrAddr     = a;
        wrData     = d;
        rdReqValid = rv;
        rdReqAddr  = ra;
        rdRspReady = rr;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            c = (mdlPtr + k) % NR;
            if (g < 0 && v[c])
                g = c;
        end
        expReady = '0;
        if (g >= 0)
            expReady[g] = 1'b1;
        checkOutput("wr_ready", 32'(wrReady), 32'(expReady));
        checkOutput("ram_write_enable", 32'(ramWriteEnable), 32'(pendWrValid));
        if (pendWrValid) begin
            checkOutput("ram_write_addr", 32'(ramWriteAddr), 32'(pendWrAddr));
            checkOutput("ram_write_data", 32'(ramWriteData), 32'(pendWrData));
        end
        checkOutput("rd_rsp_valid", 32'(rdRspValid), 32'(mdlRspValid));
        if (mdlRspValid && mdlRspKnown)
            checkOutput("rd_rsp_data", 32'(rdRspData), 32'(mdlRspData));
        expReqReady = !mdlRspValid || rr;
        fire        = rv && expReqReady;
        checkOutput("rd_req_ready", 32'(rdReqReady), 32'(expReqReady));
        checkOutput("ram_read_ready", 32'(ramReadReady), 32'(fire));
        if (fire)
            checkOutput("ram_read_addr", 32'(ramReadAddr), 32'(ra));
        checkOutput("init_done", 32'(initDone), 32'd1);

        // A read sampled this cycle sees the array before this cycle's write lands
        rdVal   = expMem[ra];
        rdKnown = expKnown[ra];
        if (pendWrValid) begin
            expMem[pendWrAddr]   = pendWrData;
            expKnown[pendWrAddr] = 1'b1;
        end
        if (g >= 0) begin
            pendWrValid = 1'b1;
            pendWrAddr  = a[g*AW +: AW];
            pendWrData  = d[g*DW +: DW];
            mdlPtr      = (g + 1) % NR;
        end else begin
            pendWrValid = 1'b0;
        end
        if (expReqReady) begin
            mdlRspValid = fire;
            if (fire) begin
                mdlRspData  = rdVal;
                mdlRspKnown = rdKnown;
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wen"}, 32'(ramWriteEnable), 32'd0);
        checkOutput({tag, "_waddr"}, 32'(ramWriteAddr), 32'd0);
        checkOutput({tag, "_wdata"}, 32'(ramWriteData), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rdRspValid), 32'd0);
        checkOutput({tag, "_init_done"}, 32'(initDone), 32'd0);
    endtask

`ifdef RAM_ARB_INIT_SWEEP_EN
    // Watch sweep addresses 0..last; request inputs held high to confirm INIT gating
    task automatic watchSweep(input int last);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            wrValid    = (i < 15) ? '1 : '0;
            rdReqValid = (i < 15);
            #1;
            checkOutput("sweep_wen", 32'(ramWriteEnable), 32'd1);
            checkOutput("sweep_addr", 32'(ramWriteAddr), 32'(i));
            checkOutput("sweep_data", 32'(ramWriteData), 32'(INITV));
            if (i < 15) begin
                checkOutput("sweep_init_done", 32'(initDone), 32'd0);
                checkOutput("sweep_wr_ready", 32'(wrReady), 32'd0);
                checkOutput("sweep_rd_req_ready", 32'(rdReqReady), 32'd0);
                checkOutput("sweep_ram_read_ready", 32'(ramReadReady), 32'd0);
            end
        end
        wrValid    = '0;
        rdReqValid = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            expMem[i]   = '0;
            expKnown[i] = 1'b0;
        end
        wrValid    = '1;
        rdReqValid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkResetValues("reset");
        checkOutput("reset_wr_ready", 32'(wrReady), 32'd0);
        checkOutput("reset_rd_req_ready", 32'(rdReqReady), 32'd0);
        checkOutput("reset_ram_read_ready", 32'(ramReadReady), 32'd0);
        wrValid    = '0;
        rdReqValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

`ifdef RAM_ARB_INIT_SWEEP_EN
        watchSweep(9);
        rst = 1'b1;
        #1;
        checkResetValues("midsweep");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watchSweep(15);
        for (int i = 0; i < DEPTH; i++) begin
            expMem[i]   = INITV;
            expKnown[i] = 1'b1;
        end
`endif

        // Sweep result readback at address 7
        applyStimulus('0, '0, '0, 1'b1, 4'd7, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 4'd0, 1'b1);

        // All requesters valid: grants rotate 0,1,2,3,0,...
        repeat (8)
            applyStimulus(4'hF, {4'd11, 4'd10, 4'd9, 4'd8}, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b0, 4'd0, 1'b1);

        // Only requesters 1 and 3: grants alternate
        repeat (6)
            applyStimulus(4'b1010, {4'd13, 4'd0, 4'd12, 4'd0}, {8'h33, 8'h00, 8'h31, 8'h00}, 1'b0, 4'd0, 1'b1);

        // Read stream: write 3=3C, 4=4D, then back-to-back reads
        applyStimulus(4'b0001, {12'd0, 4'd3}, {24'd0, 8'h3C}, 1'b0, 4'd0, 1'b1);
        applyStimulus(4'b0010, {8'd0, 4'd4, 4'd0}, {16'd0, 8'h4D, 8'h00}, 1'b0, 4'd0, 1'b1);
        repeat (2) applyStimulus('0, '0, '0, 1'b0, 4'd0, 1'b1);
        applyStimulus('0, '0, '0, 1'b1, 4'd3, 1'b1);
        applyStimulus('0, '0, '0, 1'b1, 4'd4, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 4'd0, 1'b1);

        // Backpressure with 3C pending
        applyStimulus('0, '0, '0, 1'b1, 4'd3, 1'b1);
        repeat (5) applyStimulus('0, '0, '0, 1'b1, 4'd4, 1'b0);
        applyStimulus('0, '0, '0, 1'b1, 4'd4, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 4'd0, 1'b1);

        // Randomized mixed traffic
        for (int n = 0; n < 400; n++)
            applyStimulus(NR'($urandom), (NR*AW)'($urandom), (NR*DW)'($urandom),
                          1'($urandom), AW'($urandom), ($urandom_range(0, 3) != 0));

        // Reset while a response is stalled drops it
        applyStimulus('0, '0, '0, 1'b1, 4'd5, 1'b0);
        @(negedge clk);
        rdReqValid = 1'b0;
        rst        = 1'b1;
        #1;
        checkResetValues("pending_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Controller in front of a single-clock RAM with one write port and one ready-gated read port (1-cycle registered read, output held while read_ready is low).
- Optionally sweeps the whole RAM to INIT_VALUE after reset.
- Then shares the single write port round-robin among NUM_REQ valid/ready writers.
- Exposes the read port as a full-throughput request/response stream, using read_ready to stall the RAM output register.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 10, RAM address width (depth 2^ADDR_WIDTH).
- NUM_REQ, 4, number of write requesters (>=2).
- INIT_VALUE, 0, word written to every address during the init sweep.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  NUM_REQ  per-requester write valid
- wr_ready  out  NUM_REQ  per-requester write accept
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice i
- wr_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i in slice i
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accept
- rd_req_addr  in  ADDR_WIDTH  read address
- rd_rsp_valid  out  1  read response valid
- rd_rsp_ready  in  1  read response accept
- rd_rsp_data  out  DATA_WIDTH  read response data
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr
- ram_write_data  out  DATA_WIDTH  to RAM write_data
- ram_write_enable  out  1  to RAM write_enable
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr
- ram_read_data  in  DATA_WIDTH  from RAM read_data
- ram_read_ready  out  1  to RAM read_ready
- init_done  out  1  high once the arbiter accepts traffic

Behaviour:
- Reset values: ram_write_enable=0, ram_write_addr=0, ram_write_data=0, rd_rsp_valid=0, init_done=0, init counter=0, RR pointer=0, state=INIT.
- Reset asserted at any time, including mid-sweep or with a response pending: same values immediately; pending response is dropped.

State INIT (sweep enabled):
- Each cycle drives registered ram_write_enable=1, ram_write_addr=counter, ram_write_data=INIT_VALUE.
- Counter increments 0..2^ADDR_WIDTH-1.
- After the last address is issued: go to RUN; init_done=1 from the following cycle.
- During INIT: wr_ready=0, rd_req_ready=0, ram_read_ready=0.
- Sweep length is exactly 2^ADDR_WIDTH cycles of write_enable.

State RUN, write arbitration:
- Combinational round-robin grant among wr_valid, starting search at pointer p and wrapping NUM_REQ-1 -> 0.
- wr_ready[g]=1 only for the granted g; all others 0. wr_ready is 0 when no request is valid.
- On accept: next cycle ram_write_enable=1, ram_write_addr/data = slice g (1-cycle registered latency); p <= (g+1) mod NUM_REQ.
- No accept: ram_write_enable=0 next cycle; p unchanged.
- At most one write per cycle; sustained throughput is 1 write/cycle.

State RUN, read path:
- rd_req_ready = !rd_rsp_valid || rd_rsp_ready.
- fire = rd_req_valid && rd_req_ready.
- ram_read_addr = rd_req_addr; ram_read_ready = fire.
- rd_rsp_valid <= fire when rd_req_ready, else holds.
- rd_rsp_data = ram_read_data (combinational passthrough; the RAM holds it while ram_read_ready=0).
- Latency: request accepted cycle t -> rd_rsp_valid in t+1.
- Back-to-back reads with rd_rsp_ready held high: 1/cycle.
- Backpressure: response held stable, rd_req_ready=0; no data loss or duplication.

Read/write ordering:
- Write accepted at t reaches the RAM array at the end of t+1.
- A read accepted at t+2 or later returns the new data.
- A read accepted at t or t+1 to the same address returns the old word unless the RAM is built with bypass/cache; the arbiter adds no forwarding.

Simultaneous read and write in one cycle: independent; both proceed.

Optional Feature:
- Macro RAM_ARB_INIT_SWEEP_EN.
- Defined: INIT state and sweep as above.
- Undefined: INIT state and counter removed; state is RUN and init_done=1 from the first clock edge after rst deasserts; RAM contents undefined.

Test Plan:
- Sweep: DATA_WIDTH=8, ADDR_WIDTH=4, INIT_VALUE=8'hA5, macro defined; release rst -> exactly 16 cycles of ram_write_enable with addr 0..15, data A5, then init_done=1; reading addr 7 returns A5.
- Round-robin: NUM_REQ=4, all wr_valid held high, data = 8'h10+i -> ram_write_data sequence 10,11,12,13,10,...; each wr_ready pulses once per 4 cycles.
- Pointer skip: only requesters 1 and 3 valid after a grant to 3 -> grants alternate 1,3,1,3; requesters 0 and 2 never get wr_ready.
- Read stream: write addr 3=8'h3C and addr 4=8'h4D; stream reads 3,4 with rd_rsp_ready=1 -> rsp 3C at t+1, 4D at t+2.
- Read backpressure: rd_rsp_ready=0 for 5 cycles with rsp 3C pending -> rd_rsp_data stays 3C, rd_req_ready=0, ram_read_ready=0; release -> 3C consumed once, next read proceeds.
- Reset mid-sweep: assert rst at sweep address 9 -> outputs return to reset values immediately; after release the sweep restarts at 0 and runs a full 16 cycles.
